avalon_gpio_pio: RTL and testbench
==================================

# avalon_gpio_pio

Parametrised Avalon-MM general-purpose I/O port; successor to the fixed 8-bit output-only PIO. Provides per-bit direction control, atomic bit set/clear, synchronised input sampling, and edge capture with a maskable level interrupt. Sits on the system interconnect as a zero-wait-state slave. Drives board or NES-core control lines and samples status lines.

## Interface
- WIDTH, 8: port width, 1..32.
- RESET_VALUE, 0: data_out value after reset, WIDTH bits.
- EDGE_TYPE, 0: capture edge; 0 rising, 1 falling, 2 any.
- SYNC_STAGES, 2: input synchroniser depth, 2..4.

- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  3  word offset.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above WIDTH ignored.
- readdata  out  32  read data, combinational; bits above WIDTH read 0.
- in_port  in  WIDTH  asynchronous pin inputs.
- out_port  out  WIDTH  output data register.
- oe_port  out  WIDTH  per-bit output enable (= direction).
- irq  out  1  level interrupt, active-high.

## Operation
- Write occurs when chipselect=1 and write_n=0; takes effect on the next clk edge.
- Offset 0 DATA:
  - Write loads data_out.
  - Read returns, per bit, data_out if direction=1, else the synchronised input.
- Offset 1 DIRECTION: R/W; 1 = output.
- Offset 2 IRQ_MASK: R/W.
- Offset 3 EDGE_CAPTURE:
  - Read returns the captured bits.
  - Writing 1 clears a bit; writing 0 leaves it unchanged.
- Offset 4 OUTSET: write ORs writedata into data_out; read returns 0.
- Offset 5 OUTCLEAR: write clears data_out bits where writedata=1; read returns 0.
- Offsets 6, 7: reads return 0, writes are ignored.
- Edge detection compares the last synchroniser stage with a one-cycle-delayed copy. Edge capture covers input bits and output bits alike.
- A captured bit is sticky until cleared. If a clear and a new edge hit the same bit in the same cycle, the set wins.
- irq = OR(edge_capture & irq_mask), formed combinationally from registers.
- Priming counter: edge capture is suppressed until SYNC_STAGES+1 cycles after reset_n deasserts, so pin levels present at reset release are never captured.

## Timing
- Reset values:
  - data_out = RESET_VALUE.
  - direction, irq_mask, edge_capture, synchroniser and delay flops, priming counter = 0.
  - out_port = RESET_VALUE, oe_port = 0, irq = 0, readdata = 0 (address 0, all inputs low).
- Write to visible out_port or oe_port change: 1 cycle.
- Pin change to visible in DATA read: SYNC_STAGES cycles.
- Pin edge to edge_capture bit set: SYNC_STAGES+1 cycles. irq asserts in that same cycle if the bit is unmasked.
- EDGE_CAPTURE clear write: bit and irq drop 1 cycle later.
- Read latency is 0; there is no read side effect.
- Reset asserted mid-operation clears all state immediately, including any pending capture. Priming restarts on release.

## Configuration
- AVALON_GPIO_PIO_EDGE_IRQ_EN defined: edge detect, EDGE_CAPTURE, IRQ_MASK, the priming counter and irq are present.
- Not defined:
  - Offsets 2 and 3 read 0 and ignore writes.
  - irq is tied to 0.
  - The edge, delay and priming logic is removed.
  - The synchroniser and all other registers are retained.

## Structure
- Package avalon_gpio_pio_pkg holds:
  - Register offset constants: DATA, DIRECTION, IRQ_MASK, EDGE_CAPTURE, OUTSET, OUTCLEAR.
  - EDGE_TYPE encodings as localparams.
  - Parameter range checks.
- One sub-module, gpio_sync: a SYNC_STAGES-deep per-bit flop chain with asynchronous reset to 0, instantiated once at WIDTH.

## Test plan
- Reset with RESET_VALUE=8'hA5 -> out_port=8'hA5, oe_port=0, irq=0. DIRECTION write 8'hFF, then DATA read -> 8'hA5.
- DATA=8'h0F, OUTSET 8'hC0, then OUTCLEAR 8'h03 -> out_port steps 8'h0F, 8'hCF, 8'hCC, one cycle after each write.
- DIRECTION=8'h0F, data_out=8'h05, in_port=8'h90 -> DATA read 8'h95 after SYNC_STAGES cycles.
- EDGE_TYPE=0, mask=8'h01, in_port[0] rises -> EDGE_CAPTURE=8'h01 and irq=1 exactly SYNC_STAGES+1 cycles later. Writing 8'h01 to EDGE_CAPTURE -> irq=0 next cycle. A falling edge sets nothing.
- Clear write to bit 0 in the same cycle the edge registers -> bit remains 1 and irq stays 1.
- in_port=8'hFF held through reset release -> EDGE_CAPTURE stays 0 and irq stays 0. A mid-capture reset pulse clears capture and irq.

Source files
------------

// File: rtl/avalon_gpio_pio_pkg.sv
// Shared constants for the Avalon-MM GPIO port: register map, capture-edge
// encodings and parameter range checks.
package avalon_gpio_pio_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned BUS_W  = 32;

    typedef enum logic [ADDR_W-1:0] {
        DATA         = 3'd0,
        DIRECTION    = 3'd1,
        IRQ_MASK     = 3'd2,
        EDGE_CAPTURE = 3'd3,
        OUTSET       = 3'd4,
        OUTCLEAR     = 3'd5,
        RSVD6        = 3'd6,
        RSVD7        = 3'd7
    } gpio_reg_e;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

    localparam int unsigned WIDTH_MIN = 1;
    localparam int unsigned WIDTH_MAX = 32;
    localparam int unsigned SYNC_MIN  = 2;
    localparam int unsigned SYNC_MAX  = 4;

    function automatic bit params_valid(input int unsigned width,
                                        input int unsigned sync_stages,
                                        input int unsigned edge_type);
        return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
               (sync_stages >= SYNC_MIN) && (sync_stages <= SYNC_MAX) &&
               (edge_type <= EDGE_ANY);
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// Per-bit multi-flop synchroniser for asynchronous pin inputs.
module gpio_sync #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/avalon_gpio_pio.sv
// Avalon-MM GPIO port: direction, atomic set/clear, synchronised inputs.
// Edge capture, IRQ mask and irq exist only with AVALON_GPIO_PIO_EDGE_IRQ_EN.
module avalon_gpio_pio
    import avalon_gpio_pio_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      EDGE_TYPE   = EDGE_RISE,
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [BUS_W-1:0]  writedata,
    output logic [BUS_W-1:0]  readdata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [WIDTH-1:0]  out_port,
    output logic [WIDTH-1:0]  oe_port,
    output logic              irq
);

    if (!params_valid(WIDTH, SYNC_STAGES, EDGE_TYPE)) begin : g_param_check
        $error("avalon_gpio_pio: WIDTH, SYNC_STAGES or EDGE_TYPE out of range");
    end

    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic             unused_wdata;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] data_rd;
    logic [WIDTH-1:0] mask_rd;
    logic [WIDTH-1:0] cap_rd;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] dir_q, dir_d;

    assign wr_en        = chipselect & ~write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (in_port),
        .q_o     (in_sync)
    );

    // Output data and direction registers, including atomic set/clear.
    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        if (wr_en) begin
            case (address)
                DATA:      data_out_d = wdata;
                DIRECTION: dir_d      = wdata;
                OUTSET:    data_out_d = data_out_q | wdata;
                OUTCLEAR:  data_out_d = data_out_q & ~wdata;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= RESET_VALUE;
            dir_q      <= '0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
        end
    end

    assign out_port = data_out_q;
    assign oe_port  = dir_q;
    assign data_rd  = (data_out_q & dir_q) | (in_sync & ~dir_q);

`ifdef AVALON_GPIO_PIO_EDGE_IRQ_EN
    localparam int unsigned PRIME_MAX = SYNC_STAGES + 1;
    localparam int unsigned PRIME_W   = $clog2(PRIME_MAX + 1);

    logic [WIDTH-1:0]   mask_q, mask_d;
    logic [WIDTH-1:0]   cap_q, cap_d;
    logic [WIDTH-1:0]   dly_q;
    logic [WIDTH-1:0]   edge_hit;
    logic [WIDTH-1:0]   cap_clr;
    logic [PRIME_W-1:0] prime_q, prime_d;
    logic               primed;

    // Reset zeros in the sync/delay chain would look like edges; hold off until flushed.
    assign primed = (prime_q == PRIME_W'(PRIME_MAX));

    always_comb begin
        edge_hit = in_sync & ~dly_q;
        if (EDGE_TYPE == EDGE_FALL) begin
            edge_hit = ~in_sync & dly_q;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            edge_hit = in_sync ^ dly_q;
        end
    end

    // A new edge beats a same-cycle write-1-to-clear.
    always_comb begin
        mask_d  = mask_q;
        cap_clr = '0;
        prime_d = primed ? prime_q : prime_q + PRIME_W'(1);
        if (wr_en && (address == IRQ_MASK)) begin
            mask_d = wdata;
        end
        if (wr_en && (address == EDGE_CAPTURE)) begin
            cap_clr = wdata;
        end
        cap_d = (cap_q & ~cap_clr) | (primed ? edge_hit : '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q  <= '0;
            cap_q   <= '0;
            dly_q   <= '0;
            prime_q <= '0;
        end else begin
            mask_q  <= mask_d;
            cap_q   <= cap_d;
            dly_q   <= in_sync;
            prime_q <= prime_d;
        end
    end

    assign irq     = |(cap_q & mask_q);
    assign mask_rd = mask_q;
    assign cap_rd  = cap_q;
`else
    assign irq     = 1'b0;
    assign mask_rd = '0;
    assign cap_rd  = '0;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            DATA:         readdata = BUS_W'(data_rd);
            DIRECTION:    readdata = BUS_W'(dir_q);
            IRQ_MASK:     readdata = BUS_W'(mask_rd);
            EDGE_CAPTURE: readdata = BUS_W'(cap_rd);
            default:      ;
        endcase
    end

endmodule

// File: tb/tb_avalon_gpio_pio.sv
// Self-checking bench for avalon_gpio_pio: directed vector table, edge/reset
// sequences and a randomised phase against a history-based reference model.
module tb_avalon_gpio_pio;

    localparam int unsigned W  = 8;
    localparam int unsigned S  = 2;
    localparam logic [7:0]  RV = 8'hA5;
`ifdef AVALON_GPIO_PIO_EDGE_IRQ_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  in_port;
    logic [7:0]  out_port;
    logic [7:0]  oe_port;
    logic        irq;

    avalon_gpio_pio #(
        .WIDTH       (W),
        .RESET_VALUE (RV),
        .EDGE_TYPE   (0),
        .SYNC_STAGES (S)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .oe_port    (oe_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register values plus a history of pin samples; the
    // synchronised view is simply the pin value from S clock edges ago.
    logic [7:0] m_out, m_dir, m_mask, m_cap;
    logic [7:0] hist[$];
    int         m_edges;

    function automatic logic [7:0] hist_get(input int k);
        if (hist.size() >= k) return hist[hist.size() - k];
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_out = RV; m_dir = 8'h00; m_mask = 8'h00; m_cap = 8'h00;
        hist.delete();
        m_edges = 0;
    endtask

    task automatic model_step();
        logic [7:0] sync_v, dly_v, rise, clr, wd, new_cap;
        logic       wr;
        sync_v = hist_get(S);
        dly_v  = hist_get(S + 1);
        rise   = sync_v & ~dly_v;
        wr     = chipselect && !write_n;
        wd     = writedata[7:0];
        clr    = (EDGE_EN && wr && address == 3'd3) ? wd : 8'h00;
        new_cap = (m_cap & ~clr) | ((EDGE_EN && (m_edges + 1 >= int'(S) + 2)) ? rise : 8'h00);
        if (wr) begin
            case (address)
                3'd0: m_out = wd;
                3'd1: m_dir = wd;
                3'd2: if (EDGE_EN) m_mask = wd;
                3'd4: m_out = m_out | wd;
                3'd5: m_out = m_out & ~wd;
                default: ;
            endcase
        end
        m_cap = new_cap;
        hist.push_back(in_port);
        if (hist.size() > 8) void'(hist.pop_front());
        m_edges++;
    endtask

    function automatic logic [31:0] model_rd(input logic [2:0] a);
        logic [7:0] sync_v;
        sync_v = hist_get(S);
        case (a)
            3'd0: return {24'h0, (m_out & m_dir) | (sync_v & ~m_dir)};
            3'd1: return {24'h0, m_dir};
            3'd2: return EDGE_EN ? {24'h0, m_mask} : 32'h0;
            3'd3: return EDGE_EN ? {24'h0, m_cap} : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic compare_all(input string tag);
        check({tag, "_out"}, 32'(out_port), 32'(m_out));
        check({tag, "_oe"},  32'(oe_port),  32'(m_dir));
        check({tag, "_irq"}, 32'(irq),      32'(EDGE_EN && ((m_cap & m_mask) != 8'h00)));
        check({tag, "_rd"},  readdata,      model_rd(address));
    endtask

    task automatic drive(input logic [2:0] a, input logic c, input logic w,
                         input logic [31:0] d, input logic [7:0] p);
        address = a; chipselect = c; write_n = w; writedata = d; in_port = p;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_step();
        @(negedge clk);
        #1;
        compare_all("cyc");
    endtask

    task automatic do_reset(input logic [7:0] p);
        reset_n = 1'b0;
        drive(3'd0, 1'b0, 1'b1, 32'h0, p);
        #1;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    typedef struct {
        logic [2:0]  addr;
        logic        cs;
        logic        wn;
        logic [31:0] wd;
        logic [7:0]  pin;
        logic [31:0] exp_rd;
        logic [7:0]  exp_out;
        logic [7:0]  exp_oe;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pin;
        // exp_rd is the read before the edge; exp_out/exp_oe are after it.
        vecs[0]  = '{3'd1, 1'b1, 1'b0, 32'h0000_00FF, 8'h00, 32'h00, 8'hA5, 8'hFF};
        vecs[1]  = '{3'd0, 1'b1, 1'b1, 32'h0000_0000, 8'h00, 32'hA5, 8'hA5, 8'hFF};
        vecs[2]  = '{3'd0, 1'b1, 1'b0, 32'hFFFF_FF0F, 8'h00, 32'hA5, 8'h0F, 8'hFF};
        vecs[3]  = '{3'd4, 1'b1, 1'b0, 32'h0000_00C0, 8'h00, 32'h00, 8'hCF, 8'hFF};
        vecs[4]  = '{3'd5, 1'b1, 1'b0, 32'h0000_0003, 8'h00, 32'h00, 8'hCC, 8'hFF};
        vecs[5]  = '{3'd1, 1'b1, 1'b0, 32'h0000_000F, 8'h00, 32'hFF, 8'hCC, 8'h0F};
        vecs[6]  = '{3'd0, 1'b1, 1'b0, 32'h0000_0005, 8'h90, 32'h0C, 8'h05, 8'h0F};
        vecs[7]  = '{3'd0, 1'b1, 1'b1, 32'h0000_0000, 8'h90, 32'h05, 8'h05, 8'h0F};
        vecs[8]  = '{3'd0, 1'b1, 1'b1, 32'h0000_0000, 8'h90, 32'h95, 8'h05, 8'h0F};
        vecs[9]  = '{3'd6, 1'b1, 1'b0, 32'h0000_00FF, 8'h90, 32'h00, 8'h05, 8'h0F};
        vecs[10] = '{3'd7, 1'b1, 1'b1, 32'h0000_0000, 8'h90, 32'h00, 8'h05, 8'h0F};
        vecs[11] = '{3'd0, 1'b0, 1'b0, 32'h0000_00FF, 8'h90, 32'h95, 8'h05, 8'h0F};

        // Reset state
        reset_n = 1'b0;
        drive(3'd0, 1'b0, 1'b1, 32'h0, 8'h00);
        #12;
        check("rst_out", 32'(out_port), 32'hA5);
        check("rst_oe",  32'(oe_port),  32'h00);
        check("rst_irq", 32'(irq),      32'h0);
        check("rst_rd",  readdata,      32'h0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        #1;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].addr, vecs[i].cs, vecs[i].wn, vecs[i].wd, vecs[i].pin);
            #1;
            check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
            tick();
            check($sformatf("vec%0d_out", i), 32'(out_port), 32'(vecs[i].exp_out));
            check($sformatf("vec%0d_oe", i),  32'(oe_port),  32'(vecs[i].exp_oe));
            check($sformatf("vec%0d_irq", i), 32'(irq),      32'h0);
        end

        // Rising edge on bit 0: capture and irq exactly S+1 cycles later
        do_reset(8'h00);
        for (int i = 0; i < 5; i++) tick();
        drive(3'd2, 1'b1, 1'b0, 32'h01, 8'h00);
        tick();
        drive(3'd3, 1'b1, 1'b1, 32'h0, 8'h01);
        tick();
        check("edge_early1_irq", 32'(irq), 32'h0);
        tick();
        check("edge_early2_irq", 32'(irq), 32'h0);
        check("edge_early2_cap", readdata, 32'h0);
        tick();
        check("edge_irq", 32'(irq), 32'(EDGE_EN));
        check("edge_cap", readdata, EDGE_EN ? 32'h01 : 32'h00);

        // Write-1-to-clear drops bit and irq one cycle later
        drive(3'd3, 1'b1, 1'b0, 32'h01, 8'h01);
        tick();
        check("clr_irq", 32'(irq), 32'h0);
        check("clr_cap", readdata, 32'h0);

        // Falling edge is not captured with EDGE_TYPE rising
        drive(3'd3, 1'b1, 1'b1, 32'h0, 8'h00);
        for (int i = 0; i < 5; i++) tick();
        check("fall_irq", 32'(irq), 32'h0);
        check("fall_cap", readdata, 32'h0);

        // Clear landing in the same cycle as a new edge: the set wins
        drive(3'd3, 1'b1, 1'b1, 32'h0, 8'h01);
        tick();
        tick();
        drive(3'd3, 1'b1, 1'b0, 32'h01, 8'h01);
        tick();
        check("race_irq", 32'(irq), 32'(EDGE_EN));
        check("race_cap", readdata, EDGE_EN ? 32'h01 : 32'h00);
        drive(3'd3, 1'b1, 1'b1, 32'h0, 8'h01);
        tick();
        check("sticky_cap", readdata, EDGE_EN ? 32'h01 : 32'h00);

        // Asynchronous reset pulse mid-capture clears everything at once
        reset_n = 1'b0;
        in_port = 8'hFF;
        #1;
        check("midrst_irq", 32'(irq),      32'h0);
        check("midrst_cap", readdata,      32'h0);
        check("midrst_out", 32'(out_port), 32'hA5);
        check("midrst_oe",  32'(oe_port),  32'h00);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        #1;

        // Pins held high through release must not be captured
        drive(3'd2, 1'b1, 1'b0, 32'hFF, 8'hFF);
        tick();
        drive(3'd3, 1'b1, 1'b1, 32'h0, 8'hFF);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("prime%0d_cap", i), readdata, 32'h0);
            check($sformatf("prime%0d_irq", i), 32'(irq), 32'h0);
        end

        // Randomised traffic against the model
        pin = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset(pin);
            if ($urandom_range(0, 3) == 0) pin = 8'($urandom);
            drive(3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), $urandom, pin);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
